mem_stage: RTL and testbench

//  MEM stage of the 5-stage MIPS pipeline: consumes EX/MEM register outputs, performs lw/sw on a

---
 rtl/mem_stage_pkg.sv | 23 ++
 rtl/mem_stage_data_mem.sv | 32 +++
 rtl/mem_stage.sv | 91 +++++++++
 tb/tb_mem_stage.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: datapath widths, memory defaults
// and the MEM/WB register payload.
package mem_stage_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned REG_W         = 5;
    localparam int unsigned MEM_WORDS_DEF = 256;
    localparam int unsigned ADDR_W_DEF    = 8;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic [REG_W-1:0]  write_reg;
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] alu_result;
        logic              misalign;
    } memwb_t;

    function automatic logic branch_taken(input logic br, input logic bne, input logic z);
        return (br & z) | (bne & ~z);
    endfunction

endpackage

// File: rtl/mem_stage_data_mem.sv
// Word-addressed data memory: synchronous write, combinational read of the
// pre-edge contents, and out-of-range accesses dropped / read as zero.
module mem_stage_data_mem
    import mem_stage_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [DATA_W-3:0] i_word_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata_c
);

    // Contents are deliberately not reset; only power-up state applies.
    logic [DATA_W-1:0] r_mem [MEM_WORDS];

    logic              w_in_range;
    logic [ADDR_W-1:0] w_idx;

    assign w_in_range = (i_word_addr[DATA_W-3:ADDR_W] == '0);
    assign w_idx      = i_word_addr[ADDR_W-1:0];
    assign o_rdata_c  = w_in_range ? r_mem[w_idx] : '0;

    always_ff @(posedge clk) begin
        if (i_we && w_in_range) begin
            r_mem[w_idx] <= i_wdata;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: load/store, branch/jump redirect, MEM/WB register.
// Optional macro MEM_MISALIGN_TRAP_EN traps accesses whose ALUresult[1:0] is non-zero.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              Jump,
    input  logic              Branch,
    input  logic              Bne,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic              zero,
    input  logic [DATA_W-1:0] ALUresult,
    input  logic [DATA_W-1:0] regData2,
    input  logic [REG_W-1:0]  WriteReg,
    output logic              PCSrc,
    output logic              JumpOut,
    output logic              RegWrite_wb,
    output logic              MemtoReg_wb,
    output logic [REG_W-1:0]  WriteReg_wb,
    output logic [DATA_W-1:0] ReadData_wb,
    output logic [DATA_W-1:0] ALUresult_wb,
    output logic [DATA_W-1:0] WBdata,
    output logic              misalign
);

    logic              w_misalign;
    logic              w_mem_we;
    logic [DATA_W-1:0] w_rdata;
    memwb_t            w_wb_next;
    memwb_t            r_wb;

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misalign = (MemRead | MemWrite) & (ALUresult[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // Reset and flush both suppress the store in the same cycle.
    assign w_mem_we = MemWrite & ~flush & ~reset & ~w_misalign;

    mem_stage_data_mem #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_W    (ADDR_W)
    ) u_data_mem (
        .clk         (clk),
        .i_we        (w_mem_we),
        .i_word_addr (ALUresult[DATA_W-1:2]),
        .i_wdata     (regData2),
        .o_rdata_c   (w_rdata)
    );

    // A flushed instruction becomes an all-zero bubble.
    always_comb begin
        w_wb_next = '0;
        if (!flush) begin
            w_wb_next.reg_write  = RegWrite & ~w_misalign;
            w_wb_next.mem_to_reg = MemtoReg;
            w_wb_next.write_reg  = WriteReg;
            w_wb_next.read_data  = MemRead ? w_rdata : '0;
            w_wb_next.alu_result = ALUresult;
            w_wb_next.misalign   = w_misalign;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb <= '0;
        end else begin
            r_wb <= w_wb_next;
        end
    end

    assign PCSrc        = branch_taken(Branch, Bne, zero) & ~flush;
    assign JumpOut      = Jump & ~flush;
    assign RegWrite_wb  = r_wb.reg_write;
    assign MemtoReg_wb  = r_wb.mem_to_reg;
    assign WriteReg_wb  = r_wb.write_reg;
    assign ReadData_wb  = r_wb.read_data;
    assign ALUresult_wb = r_wb.alu_result;
    assign misalign     = r_wb.misalign;
    assign WBdata       = r_wb.mem_to_reg ? r_wb.read_data : r_wb.alu_result;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver issues transactions and queues the
// expected response from a word-array memory model; a monitor pops and compares.
module tb_mem_stage;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        reset, flush, Jump, Branch, Bne, MemRead, MemWrite, MemtoReg, RegWrite, zero;
    logic [31:0] ALUresult, regData2;
    logic [4:0]  WriteReg;
    logic        PCSrc, JumpOut, RegWrite_wb, MemtoReg_wb, misalign;
    logic [4:0]  WriteReg_wb;
    logic [31:0] ReadData_wb, ALUresult_wb, WBdata;

    mem_stage dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .Jump         (Jump),
        .Branch       (Branch),
        .Bne          (Bne),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .MemtoReg     (MemtoReg),
        .RegWrite     (RegWrite),
        .zero         (zero),
        .ALUresult    (ALUresult),
        .regData2     (regData2),
        .WriteReg     (WriteReg),
        .PCSrc        (PCSrc),
        .JumpOut      (JumpOut),
        .RegWrite_wb  (RegWrite_wb),
        .MemtoReg_wb  (MemtoReg_wb),
        .WriteReg_wb  (WriteReg_wb),
        .ReadData_wb  (ReadData_wb),
        .ALUresult_wb (ALUresult_wb),
        .WBdata       (WBdata),
        .misalign     (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pcsrc;
        logic        jump;
        logic        rw;
        logic        m2r;
        logic [4:0]  wreg;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [31:0] wbdata;
        logic        mis;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [256];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // One instruction per clock: drive on the falling edge, queue expected result.
    task automatic txn(input bit rst, input bit fl, input bit j, input bit br, input bit bn,
                       input bit rd, input bit wr, input bit m2r, input bit rw, input bit z,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] wreg);
        exp_t e;
        bit   in_range;
        bit   mis;
        int   idx;
        @(negedge clk);
        reset = rst; flush = fl; Jump = j; Branch = br; Bne = bn;
        MemRead = rd; MemWrite = wr; MemtoReg = m2r; RegWrite = rw; zero = z;
        ALUresult = addr; regData2 = wdata; WriteReg = wreg;

        e.pcsrc  = !fl && ((br && z) || (bn && !z));
        e.jump   = j && !fl;
        e.rw     = 1'b0; e.m2r = 1'b0; e.wreg = '0; e.rdata = '0; e.alu = '0; e.mis = 1'b0;
        in_range = (addr < 32'd1024);
        idx      = int'((addr / 32'd4) % 32'd256);
        mis      = TRAP && (rd || wr) && (addr % 32'd4 != 0);
        if (!rst && !fl) begin
            e.rw    = rw && !mis;
            e.m2r   = m2r;
            e.wreg  = wreg;
            e.alu   = addr;
            e.mis   = mis;
            e.rdata = (rd && in_range) ? model_mem[idx] : 32'h0;
            if (wr && in_range && !mis) model_mem[idx] = wdata;
        end
        e.wbdata = e.m2r ? e.rdata : e.alu;
        exp_q.push_back(e);
    endtask

    // Monitor: inputs are held from the falling edge, so comb outputs still
    // reflect the popped instruction one unit after the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("PCSrc",        32'(PCSrc),        32'(e.pcsrc));
                chk("JumpOut",      32'(JumpOut),      32'(e.jump));
                chk("RegWrite_wb",  32'(RegWrite_wb),  32'(e.rw));
                chk("MemtoReg_wb",  32'(MemtoReg_wb),  32'(e.m2r));
                chk("WriteReg_wb",  32'(WriteReg_wb),  32'(e.wreg));
                chk("ReadData_wb",  ReadData_wb,       e.rdata);
                chk("ALUresult_wb", ALUresult_wb,      e.alu);
                chk("WBdata",       WBdata,            e.wbdata);
                chk("misalign",     32'(misalign),     32'(e.mis));
            end
        end
    end

    initial begin
        logic [31:0] a;
        int          sel;
        reset = 1'b1; flush = 1'b0; Jump = 1'b0; Branch = 1'b0; Bne = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0; zero = 1'b0;
        ALUresult = '0; regData2 = '0; WriteReg = '0;

        //  rst fl j br bn rd wr m2r rw z
        txn(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 5'd1);
        txn(1, 1, 1, 0, 0, 1, 0, 1, 1, 0, 32'h4, 32'h0, 5'd2);

        // Give every word a known value so the model is fully defined.
        for (int i = 0; i < 256; i++)
            txn(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'(i * 4), $urandom, 5'd0);

        txn(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h10, 32'hDEADBEEF, 5'd0);
        txn(0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 32'h10, 32'h0, 5'd3);
        txn(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 5'd0);
        txn(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h0, 32'h0, 5'd0);
        txn(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        txn(0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 5'd0);
        txn(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        txn(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h400, 32'h12345678, 5'd0);
        txn(0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 32'h400, 32'h0, 5'd4);
        txn(0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 32'h0, 32'h0, 5'd5);
        txn(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 32'h20, 32'h5, 5'd6);
        txn(0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 32'h20, 32'h0, 5'd7);
        txn(1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 32'h30, 32'hCAFEF00D, 5'd8);
        txn(0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 32'h30, 32'h0, 5'd9);
        txn(0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 32'h13, 32'h0, 5'd10);
        txn(0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 32'h44, 32'h0BADF00D, 5'd11);
        txn(0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 32'h44, 32'h0, 5'd12);

        for (int n = 0; n < 600; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 6)
                a = (32'($urandom_range(0, 255)) << 2) | ((sel < 2) ? 32'($urandom_range(0, 3)) : 32'h0);
            else if (sel < 8)
                a = $urandom;
            else
                a = 32'h400 + 32'($urandom_range(0, 63));
            txn(($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), a, $urandom, 5'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
